instr_fetch_decode: RTL and testbench
=====================================

# instr_fetch_decode

Front-end stage of the single-cycle RISC-V core: owns the architectural PC and fetches each instruction from instruction memory over a req/ack handshake. It decodes the instruction into the opcode, func3, func7, register-number and sign-extended immediate fields that the execute stage consumes. It presents them with a valid/done handshake, then advances the PC to PC+4 or to the redirect target returned by execute.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- imem_req  out  1  fetch request; held high until acknowledged.
- imem_addr  out  32  fetch address, equal to the current PC.
- imem_ack  in  1  memory response; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- issue_valid  out  1  decoded instruction presented to execute.
- exec_done  in  1  execute has consumed the instruction; PC-write inputs are valid this cycle.
- pcWriteEnable  in  1  redirect request from execute (taken branch, jal, jalr).
- pcWriteData  in  32  redirect target.
- opcode  out  7  instr[6:0].
- func3  out  3  instr[14:12].
- func7  out  7  instr[31:25].
- regNum0  out  5  rs1 = instr[19:15].
- regNum1  out  5  rs2 = instr[24:20].
- regWriteNum  out  5  rd = instr[11:7].
- imm  out  32  sign-extended immediate.
- PC  out  32  address of the issued instruction.
- illegal  out  1  sticky fault flag; the block is halted.

## Operation
- States: FETCH, ISSUE, HALT.
- FETCH:
  - imem_req = 1 and imem_addr = PC.
  - On imem_ack, register all decoded fields and go to ISSUE.
  - If the word is illegal, go to HALT and set illegal instead.
- ISSUE:
  - issue_valid = 1; all decoded outputs and PC are held stable.
  - On exec_done, PC <= pcWriteEnable ? {pcWriteData[31:1],1'b0} : PC+4, then go to FETCH.
  - If the redirect target has bit 1 set after bit 0 is cleared, go to HALT and set illegal.
- HALT:
  - imem_req = 0, issue_valid = 0, illegal = 1.
  - Only reset exits this state.
- Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Any other opcode is illegal.
  - instr[1:0] != 2'b11 is also illegal.
  - func3 is not checked.
- Immediate formation, all 32-bit sign-extended from instr[31]:
  - I-type (0010011, 0000011, 1100111): instr[31:20].
  - S-type: {instr[31:25], instr[11:7]}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U-type (lui, auipc): {instr[31:12], 12'b0}, no extension.
  - R-type: imm = 0.
- PC+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).

## Timing
- Reset values:
  - PC = imem_addr = RESET_PC.
  - imem_req = 0, issue_valid = 0, illegal = 0.
  - All decoded fields and imm = 0.
  - State = FETCH.
- imem_req rises in the first cycle after reset deasserts.
- imem_ack is sampled only while imem_req = 1.
  - An ack in the same cycle req first rises is legal (zero wait states).
  - An ack while req = 0 is ignored.
- Fetch → issue: issue_valid rises in the cycle after the ack cycle.
- Issue → next fetch: exec_done is sampled only while issue_valid = 1. In the cycle after exec_done, issue_valid = 0, imem_req = 1, and PC/imem_addr hold the new value.
- Throughput: minimum 2 cycles per instruction (ack in cycle N, exec_done in cycle N+1, next req in cycle N+2).
- Decoded outputs change only on the clock edge that accepts an ack. They are held unchanged through the ISSUE and FETCH states.
- Reset mid-operation, in any state: the next edge returns all outputs to their reset values. An ack outstanding or arriving in the same cycle as reset is discarded.
- exec_done arriving together with reset: reset wins and the PC is not updated.

## Test plan
- Straight-line decode:
  - Stimulus: fetch 0x00500093 (addi x1,x0,5), zero wait states.
  - Required: opcode 0x13, regWriteNum 1, regNum0 0, imm 5, PC = RESET_PC. After exec_done with pcWriteEnable = 0, imem_addr = RESET_PC+4.
- Immediate formats:
  - 0xFE000CE3 (beq x0,x0,-8) → imm 0xFFFF_FFF8.
  - 0x0020A623 (sw x2,12(x1)) → imm 12, regNum1 2.
  - 0x123452B7 (lui x5,0x12345) → imm 0x1234_5000, regWriteNum 5.
- Wait states:
  - Stimulus: hold imem_ack low for 3 cycles after req rises.
  - Required: imem_req and imem_addr stable throughout; issue_valid rises exactly 1 cycle after the ack cycle.
- Redirect:
  - exec_done with pcWriteEnable = 1, pcWriteData = 0x0000_0101 → next imem_addr = 0x0000_0100.
  - pcWriteData = 0x0000_0102 → illegal = 1, HALT, no further imem_req.
- Illegal instruction and stall:
  - Fetch 0xFFFFFFFF → illegal = 1, issue_valid stays 0, imem_req stays 0 until reset.
  - Separately, hold exec_done low for 5 cycles in ISSUE → issue_valid and all decoded outputs remain constant.
- Reset mid-fetch:
  - Stimulus: assert reset while waiting for ack, with PC = 0x40.
  - Required: next cycle PC = RESET_PC and imem_req = 0. A late ack is ignored, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_decode_if.sv
// Fetch/decode bundle: instruction-memory handshake, issue handshake to
// execute, redirect inputs and the decoded instruction fields.
interface instr_fetch_decode_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        issue_valid;
    logic        exec_done;
    logic        pcWriteEnable;
    logic [31:0] pcWriteData;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  regNum0;
    logic [4:0]  regNum1;
    logic [4:0]  regWriteNum;
    logic [31:0] imm;
    logic [31:0] PC;
    logic        illegal;

    // The fetch/decode stage itself.
    modport master (
        output imem_req, imem_addr, issue_valid,
        output opcode, func3, func7, regNum0, regNum1, regWriteNum, imm, PC, illegal,
        input  imem_ack, imem_rdata, exec_done, pcWriteEnable, pcWriteData
    );

    // Memory and execute side.
    modport slave (
        input  imem_req, imem_addr, issue_valid,
        input  opcode, func3, func7, regNum0, regNum1, regWriteNum, imm, PC, illegal,
        output imem_ack, imem_rdata, exec_done, pcWriteEnable, pcWriteData
    );
endinterface

// File: rtl/instr_fetch_decode.sv
// Front end of the single-cycle core: owns the PC, fetches over req/ack,
// decodes the word and hands the fields to execute over valid/done.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   FETCH | imem_req high with imem_addr = PC, waiting for imem_ack
//   ISSUE | decoded fields presented with issue_valid, waiting exec_done
//   HALT  | illegal word or misaligned redirect seen; only reset exits
//
// All handshake outputs are registered, so imem_req first rises on the edge
// after reset is released and drops on the edge that accepts an ack.
module instr_fetch_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_fetch_decode_if.master  bus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q;
    logic        valid_q;
    logic        illegal_q;
    logic [6:0]  opcode_q;
    logic [2:0]  func3_q;
    logic [6:0]  func7_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [4:0]  rd_q;
    logic [31:0] imm_q;

    logic        fetch_accept;
    logic        set_illegal;
    logic        dec_legal;
    logic [31:0] dec_imm;
    logic [31:0] next_pc;
    logic [31:0] instr;

    assign instr = bus.imem_rdata;

    // Opcode legality and immediate formation from the word on imem_rdata.
    always_comb begin
        dec_legal = 1'b0;
        dec_imm   = '0;
        if (instr[1:0] == 2'b11) begin
            case (instr[6:0])
                7'b0110011: begin
                    dec_legal = 1'b1;
                    dec_imm   = '0;
                end
                7'b0010011, 7'b0000011, 7'b1100111: begin
                    dec_legal = 1'b1;
                    dec_imm   = {{20{instr[31]}}, instr[31:20]};
                end
                7'b0100011: begin
                    dec_legal = 1'b1;
                    dec_imm   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                end
                7'b1100011: begin
                    dec_legal = 1'b1;
                    dec_imm   = {{19{instr[31]}}, instr[31], instr[7],
                                 instr[30:25], instr[11:8], 1'b0};
                end
                7'b1101111: begin
                    dec_legal = 1'b1;
                    dec_imm   = {{11{instr[31]}}, instr[31], instr[19:12],
                                 instr[20], instr[30:21], 1'b0};
                end
                7'b0110111, 7'b0010111: begin
                    dec_legal = 1'b1;
                    dec_imm   = {instr[31:12], 12'b0};
                end
                default: begin
                    dec_legal = 1'b0;
                    dec_imm   = '0;
                end
            endcase
        end
    end

    // Candidate PC after execute: redirect target with bit 0 cleared, else PC+4.
    always_comb begin
        next_pc = bus.pcWriteEnable ? (bus.pcWriteData & 32'hFFFF_FFFE)
                                    : pc_q + 32'd4;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state, PC update and fault detection.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_accept = 1'b0;
        set_illegal  = 1'b0;
        case (state_q)
            FETCH: begin
                // req_q is low for one cycle after reset, so an ack then is ignored.
                if (req_q && bus.imem_ack) begin
                    if (dec_legal) begin
                        fetch_accept = 1'b1;
                        state_d      = ISSUE;
                    end else begin
                        set_illegal  = 1'b1;
                        state_d      = HALT;
                    end
                end
            end
            ISSUE: begin
                if (valid_q && bus.exec_done) begin
                    // Bit 1 of the target can only be set by a redirect.
                    if (next_pc[1]) begin
                        set_illegal = 1'b1;
                        state_d     = HALT;
                    end else begin
                        pc_d        = next_pc;
                        state_d     = FETCH;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                set_illegal = 1'b1;
                state_d     = HALT;
            end
        endcase
    end

    // Registered handshake outputs, PC, sticky fault and decoded fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            opcode_q  <= '0;
            func3_q   <= '0;
            func7_q   <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
        end else begin
            pc_q      <= pc_d;
            req_q     <= (state_d == FETCH);
            valid_q   <= (state_d == ISSUE);
            illegal_q <= illegal_q | set_illegal;
            if (fetch_accept) begin
                opcode_q <= instr[6:0];
                func3_q  <= instr[14:12];
                func7_q  <= instr[31:25];
                rs1_q    <= instr[19:15];
                rs2_q    <= instr[24:20];
                rd_q     <= instr[11:7];
                imm_q    <= dec_imm;
            end
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.issue_valid = valid_q;
    assign bus.illegal     = illegal_q;
    assign bus.PC          = pc_q;
    assign bus.opcode      = opcode_q;
    assign bus.func3       = func3_q;
    assign bus.func7       = func7_q;
    assign bus.regNum0     = rs1_q;
    assign bus.regNum1     = rs2_q;
    assign bus.regWriteNum = rd_q;
    assign bus.imm         = imm_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: a decode vector table applied
// back-to-back, then hand-written sequences for stalls, redirects, faults
// and reset corner cases.
module tb_instr_fetch_decode;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    instr_fetch_decode_if bus();

    instr_fetch_decode #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs[9];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task tick;
        @(posedge clk);
        #1;
    endtask

    task idle_inputs;
        bus.imem_ack      = 1'b0;
        bus.imem_rdata    = '0;
        bus.exec_done     = 1'b0;
        bus.pcWriteEnable = 1'b0;
        bus.pcWriteData   = '0;
    endtask

    task fetch_word(input logic [31:0] w);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = w;
        tick();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
    endtask

    task finish_issue(input logic we, input logic [31:0] tgt);
        bus.exec_done     = 1'b1;
        bus.pcWriteEnable = we;
        bus.pcWriteData   = tgt;
        tick();
        bus.exec_done     = 1'b0;
        bus.pcWriteEnable = 1'b0;
        bus.pcWriteData   = '0;
    endtask

    task do_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc;

        idle_inputs();
        reset = 1'b1;

        //         instr          op     f3    f7     rs1    rs2    rd     imm
        vecs[0] = '{32'h00500093, 7'h13, 3'd0, 7'h00, 5'd0,  5'd5,  5'd1,  32'h0000_0005};
        vecs[1] = '{32'hFE000CE3, 7'h63, 3'd0, 7'h7F, 5'd0,  5'd0,  5'd25, 32'hFFFF_FFF8};
        vecs[2] = '{32'h0020A623, 7'h23, 3'd2, 7'h00, 5'd1,  5'd2,  5'd12, 32'h0000_000C};
        vecs[3] = '{32'h123452B7, 7'h37, 3'd5, 7'h09, 5'd8,  5'd3,  5'd5,  32'h1234_5000};
        vecs[4] = '{32'h402081B3, 7'h33, 3'd0, 7'h20, 5'd1,  5'd2,  5'd3,  32'h0000_0000};
        vecs[5] = '{32'hFFC12303, 7'h03, 3'd2, 7'h7F, 5'd2,  5'd28, 5'd6,  32'hFFFF_FFFC};
        vecs[6] = '{32'hFFDFF0EF, 7'h6F, 3'd7, 7'h7F, 5'd31, 5'd29, 5'd1,  32'hFFFF_FFFC};
        vecs[7] = '{32'h00001517, 7'h17, 3'd1, 7'h00, 5'd0,  5'd0,  5'd10, 32'h0000_1000};
        vecs[8] = '{32'hFFF08067, 7'h67, 3'd0, 7'h7F, 5'd1,  5'd31, 5'd0,  32'hFFFF_FFFF};

        // Reset values while reset is held.
        tick();
        tick();
        chk("rst_req",     bus.imem_req,    32'd0);
        chk("rst_addr",    bus.imem_addr,   RESET_PC);
        chk("rst_pc",      bus.PC,          RESET_PC);
        chk("rst_valid",   bus.issue_valid, 32'd0);
        chk("rst_illegal", bus.illegal,     32'd0);
        chk("rst_opcode",  bus.opcode,      32'd0);
        chk("rst_rd",      bus.regWriteNum, 32'd0);
        chk("rst_imm",     bus.imm,         32'd0);

        reset = 1'b0;
        tick();
        chk("first_req",  bus.imem_req,  32'd1);
        chk("first_addr", bus.imem_addr, RESET_PC);

        // Decode table, zero wait states, no redirects.
        exp_pc = RESET_PC;
        for (int i = 0; i < 9; i++) begin
            chk("vec_addr", bus.imem_addr, exp_pc);
            fetch_word(vecs[i].instr);
            chk("vec_valid",   bus.issue_valid, 32'd1);
            chk("vec_req_lo",  bus.imem_req,    32'd0);
            chk("vec_opcode",  bus.opcode,      vecs[i].opcode);
            chk("vec_func3",   bus.func3,       vecs[i].f3);
            chk("vec_func7",   bus.func7,       vecs[i].f7);
            chk("vec_rs1",     bus.regNum0,     vecs[i].rs1);
            chk("vec_rs2",     bus.regNum1,     vecs[i].rs2);
            chk("vec_rd",      bus.regWriteNum, vecs[i].rd);
            chk("vec_imm",     bus.imm,         vecs[i].imm);
            chk("vec_pc",      bus.PC,          exp_pc);
            chk("vec_illegal", bus.illegal,     32'd0);
            finish_issue(1'b0, 32'h0);
            exp_pc = exp_pc + 32'd4;
            chk("vec_next_valid", bus.issue_valid, 32'd0);
            chk("vec_next_req",   bus.imem_req,    32'd1);
        end

        // Wait states: req and addr hold while ack stays low.
        for (int k = 0; k < 3; k++) begin
            chk("ws_req",   bus.imem_req,    32'd1);
            chk("ws_addr",  bus.imem_addr,   exp_pc);
            chk("ws_valid", bus.issue_valid, 32'd0);
            tick();
        end
        fetch_word(32'h00500093);
        chk("ws_valid_rise", bus.issue_valid, 32'd1);

        // Execute stall: outputs frozen while exec_done is low.
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid",  bus.issue_valid, 32'd1);
            chk("stall_opcode", bus.opcode,      32'h13);
            chk("stall_imm",    bus.imm,         32'd5);
            chk("stall_rd",     bus.regWriteNum, 32'd1);
            chk("stall_pc",     bus.PC,          exp_pc);
            chk("stall_req",    bus.imem_req,    32'd0);
            tick();
        end

        // Redirect with bit 0 set is cleared to an aligned target.
        finish_issue(1'b1, 32'h0000_0101);
        chk("redir_addr",  bus.imem_addr,   32'h0000_0100);
        chk("redir_req",   bus.imem_req,    32'd1);
        chk("redir_valid", bus.issue_valid, 32'd0);

        // PC+4 wraps at the top of the address space.
        fetch_word(32'h00500093);
        finish_issue(1'b1, 32'hFFFF_FFFC);
        chk("wrap_top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        fetch_word(32'h402081B3);
        chk("wrap_top_pc", bus.PC, 32'hFFFF_FFFC);
        finish_issue(1'b0, 32'h0);
        chk("wrap_addr", bus.imem_addr, 32'h0000_0000);

        // Reset while waiting for ack with PC = 0x40; late ack must be ignored.
        fetch_word(32'h00500093);
        finish_issue(1'b1, 32'h0000_0040);
        chk("mid_addr40", bus.imem_addr, 32'h0000_0040);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_pc",     bus.PC,          RESET_PC);
        chk("mid_req",    bus.imem_req,    32'd0);
        chk("mid_valid",  bus.issue_valid, 32'd0);
        chk("mid_opcode", bus.opcode,      32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h123452B7;
        tick();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        chk("late_ack_valid",  bus.issue_valid, 32'd0);
        chk("late_ack_opcode", bus.opcode,      32'd0);
        chk("late_ack_req",    bus.imem_req,    32'd1);
        chk("late_ack_addr",   bus.imem_addr,   RESET_PC);
        fetch_word(32'h0020A623);
        chk("restart_valid", bus.issue_valid, 32'd1);
        chk("restart_imm",   bus.imem_req == 1'b0 ? bus.imm : 32'hDEAD_BEEF, 32'd12);
        chk("restart_pc",    bus.PC,          RESET_PC);

        // exec_done coinciding with reset: reset wins, no PC update.
        finish_issue(1'b1, 32'h0000_0080);
        fetch_word(32'h00500093);
        chk("rd_pc80", bus.PC, 32'h0000_0080);
        reset             = 1'b1;
        bus.exec_done     = 1'b1;
        bus.pcWriteEnable = 1'b1;
        bus.pcWriteData   = 32'h0000_0200;
        tick();
        reset = 1'b0;
        idle_inputs();
        chk("rd_pc",    bus.PC,          RESET_PC);
        chk("rd_valid", bus.issue_valid, 32'd0);
        chk("rd_req",   bus.imem_req,    32'd0);
        tick();
        chk("rd_req_after", bus.imem_req,  32'd1);
        chk("rd_addr",      bus.imem_addr, RESET_PC);

        // Misaligned redirect halts the block.
        fetch_word(32'h00500093);
        finish_issue(1'b1, 32'h0000_0102);
        chk("mis_illegal", bus.illegal,     32'd1);
        chk("mis_req",     bus.imem_req,    32'd0);
        chk("mis_valid",   bus.issue_valid, 32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h00500093;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mis_hold_req",     bus.imem_req,    32'd0);
            chk("mis_hold_valid",   bus.issue_valid, 32'd0);
            chk("mis_hold_illegal", bus.illegal,     32'd1);
        end
        idle_inputs();

        // Illegal instruction word halts; decoded fields keep the last legal ones.
        do_reset();
        chk("ill_clear", bus.illegal, 32'd0);
        fetch_word(32'h00500093);
        finish_issue(1'b0, 32'h0);
        fetch_word(32'hFFFF_FFFF);
        chk("ill_flag",   bus.illegal,     32'd1);
        chk("ill_valid",  bus.issue_valid, 32'd0);
        chk("ill_req",    bus.imem_req,    32'd0);
        chk("ill_opcode", bus.opcode,      32'h13);
        chk("ill_imm",    bus.imm,         32'd5);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ill_hold_req",   bus.imem_req,    32'd0);
            chk("ill_hold_valid", bus.issue_valid, 32'd0);
        end

        // Legal opcode pattern but instr[1:0] != 2'b11.
        do_reset();
        fetch_word(32'h00500091);
        chk("lowbits_illegal", bus.illegal,     32'd1);
        chk("lowbits_valid",   bus.issue_valid, 32'd0);

        // Recovery after reset.
        do_reset();
        fetch_word(32'h00500093);
        chk("recover_valid",   bus.issue_valid, 32'd1);
        chk("recover_illegal", bus.illegal,     32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
